dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the word-addressed data_memory block.
- Requester 0 is the pipeline MEM stage; requester 1 is the debug/program-loader port.
- Accepts one request at a time via valid/ready, drives memory address/write_data/mem_write/mem_read for exactly one cycle, then returns a registered response to the granted requester.
- Round-robin fairness so neither port starves.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr_arb2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

    function automatic logic addr_misaligned(input logic [1:0] lo);
        return (lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the port that did not win last time is granted.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    // One-hot winner selection from the current requests and the previous winner
    always_comb begin
        w_grant = 2'b00;
        case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11: begin
                if (r_last_grant == REQ_DBG) begin
                    w_grant = 2'b01;
                end else begin
                    w_grant = 2'b10;
                end
            end
            default: w_grant = 2'b00;
        endcase
    end

    // Remember the most recent winner; reset favours the CPU port on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_DBG;
        end else if (i_advance && (w_grant != 2'b00)) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of data_memory: accept one request, one access cycle, registered response.
// Build option DMEM_ARB_ALIGN_CHECK_EN: misaligned requests skip memory and return rX_rsp_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_req_we,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_req_we,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic              r0_rsp_err,
    output logic              r1_rsp_err,
`endif
    output logic              busy
);

    arb_state_t        r_state;
    arb_req_t          r_hold;
    logic              r_gnt_id;
    logic              r_mem_write;
    logic              r_mem_read;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata0;
    logic [DATA_W-1:0] r_rsp_rdata1;
    logic              r_busy;

    logic              w_idle;
    logic [1:0]        w_grant;
    arb_req_t          w_sel_req;
    logic              w_sel_mis;
    logic              w_hold_mis;
    logic              w_rsp_ready;
    logic [DATA_W-1:0] w_access_rdata;

    assign w_idle = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (reset),
        .i_valid   ({r1_req_valid, r0_req_valid}),
        .i_advance (w_idle),
        .o_grant   (w_grant)
    );

    // Steer the winning port's request into the common request struct
    always_comb begin
        w_sel_req = '0;
        if (w_grant[1]) begin
            w_sel_req.we    = r1_req_we;
            w_sel_req.addr  = ARB_ADDR_W'(r1_req_addr);
            w_sel_req.wdata = ARB_DATA_W'(r1_req_wdata);
        end else begin
            w_sel_req.we    = r0_req_we;
            w_sel_req.addr  = ARB_ADDR_W'(r0_req_addr);
            w_sel_req.wdata = ARB_DATA_W'(r0_req_wdata);
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_sel_mis  = addr_misaligned(w_sel_req.addr[1:0]);
    assign w_hold_mis = addr_misaligned(r_hold.addr[1:0]);
`else
    assign w_sel_mis  = 1'b0;
    assign w_hold_mis = 1'b0;
`endif

    assign w_rsp_ready    = r_gnt_id ? r1_rsp_ready : r0_rsp_ready;
    assign w_access_rdata = (r_hold.we || w_hold_mis) ? {DATA_W{1'b0}} : mem_read_data;

    // Sequencer: IDLE accepts, ACCESS drives memory for one cycle, RESP waits for the consumer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_gnt_id     <= REQ_CPU;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata0 <= {DATA_W{1'b0}};
            r_rsp_rdata1 <= {DATA_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_hold      <= w_sel_req;
                        r_gnt_id    <= w_grant[1];
                        r_mem_write <= w_sel_req.we && !w_sel_mis;
                        r_mem_read  <= !w_sel_req.we && !w_sel_mis;
                        r_busy      <= 1'b1;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    if (r_gnt_id == REQ_DBG) begin
                        r_rsp_rdata1   <= w_access_rdata;
                        r_rsp_valid[1] <= 1'b1;
                    end else begin
                        r_rsp_rdata0   <= w_access_rdata;
                        r_rsp_valid[0] <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_rsp_ready) begin
                        r_rsp_valid <= 2'b00;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_rsp_valid <= 2'b00;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic [1:0] r_rsp_err;

    // Error flag accompanies rsp_valid for a misaligned request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_err <= 2'b00;
        end else if ((r_state == ACCESS) && (r_gnt_id == REQ_DBG)) begin
            r_rsp_err <= {w_hold_mis, 1'b0};
        end else if (r_state == ACCESS) begin
            r_rsp_err <= {1'b0, w_hold_mis};
        end else if ((r_state == RESP) && w_rsp_ready) begin
            r_rsp_err <= 2'b00;
        end
    end

    assign r0_rsp_err = r_rsp_err[0];
    assign r1_rsp_err = r_rsp_err[1];
`endif

    // Ready is combinational in IDLE and forced low while reset is asserted
    assign r0_req_ready   = reset && w_idle && w_grant[0];
    assign r1_req_ready   = reset && w_idle && w_grant[1];
    assign r0_rsp_valid   = r_rsp_valid[0];
    assign r1_rsp_valid   = r_rsp_valid[1];
    assign r0_rsp_rdata   = r_rsp_rdata0;
    assign r1_rsp_rdata   = r_rsp_rdata1;
    assign mem_address    = r_hold.addr[ADDR_W-1:0];
    assign mem_write_data = r_hold.wdata[DATA_W-1:0];
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign busy           = r_busy;

endmodule
